mem_bus_ctrl: RTL and testbench

Data-memory access controller at the MEM stage of the MIPS pipeline. It drives the MEM→MMID pipeline-register controls (`MEM_MMID_en`, `MEM_MMID_clr`) and the upstream stall. It also runs a request/acknowledge handshake with a variable-latency data bus for every load and store. The block freezes MEM and earlier stages while a transfer is outstanding, inserts bubbles into MMID, and delivers the captured read data with the instruction when it advances.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_bus_timer.sv | 36 +++
 rtl/mem_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MEM-stage data-bus controller: FSM state encoding
// and the data-bus-error exception code consumed by downstream exception logic.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_bus_state_e;

    localparam logic [4:0] EXC_DBE = 5'd7;

endpackage

// File: rtl/mem_bus_timer.sv
// Saturating bus-wait counter with clear/enable; flags expiry when the count
// reaches TIMEOUT_CYCLES. Only instantiated when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_timer
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    // Wait-cycle counter: cleared on request issue, holds at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (r_cnt == CNT_TO);

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-memory access controller: bus request/ack handshake, pipeline
// stall and MMID bubble control. Optional timeout enabled by MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_clr,
    input  logic        LOAD_MEM,
    input  logic        STORE_MEM,
    input  logic        EXC_MEM_nz,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  be_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        MEM_MMID_en,
    output logic        MEM_MMID_clr,
    output logic        stall_mem,
    output logic [31:0] rdata_out,
    output logic        bus_err
);

    mem_bus_state_e r_state;
    mem_bus_state_e w_next_state;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_rdata_q;
    logic        r_err_q;

    logic w_go;
    logic w_expired;
    logic w_issue;

    assign w_go    = (LOAD_MEM | STORE_MEM) & ~EXC_MEM_nz & ~int_clr;
    assign w_issue = (r_state == ST_IDLE) & w_go;

`ifdef MEM_BUS_TIMEOUT_EN
    logic w_cnt_en;
    assign w_cnt_en = (r_state == ST_WAIT) | (r_state == ST_DRAIN);

    mem_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_issue),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{CNT_W'(TIMEOUT_CYCLES)};
    assign w_expired    = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pipeline-control decode; stalled states hold MEM and bubble MMID
    always_comb begin
        w_next_state = r_state;
        MEM_MMID_en  = 1'b0;
        MEM_MMID_clr = 1'b0;
        stall_mem    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    stall_mem    = 1'b1;
                    MEM_MMID_clr = 1'b1;
                    w_next_state = ST_WAIT;
                end else begin
                    MEM_MMID_en  = 1'b1;
                end
            end
            ST_WAIT: begin
                stall_mem    = 1'b1;
                MEM_MMID_clr = 1'b1;
                // A flushed instruction whose transfer still finishes this cycle needs no drain
                if (bus_ack || w_expired) begin
                    w_next_state = int_clr ? ST_IDLE : ST_DONE;
                end else if (int_clr) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_DONE: begin
                MEM_MMID_en  = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                stall_mem    = 1'b1;
                MEM_MMID_clr = 1'b1;
                if (bus_ack || w_expired) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                MEM_MMID_en  = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Bus request registers and captured completion data/status
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_be    <= 4'h0;
            r_rdata_q   <= 32'h0000_0000;
            r_err_q     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= STORE_MEM;
                        r_bus_addr  <= addr_in;
                        r_bus_wdata <= wdata_in;
                        r_bus_be    <= be_in;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!int_clr) begin
                            r_err_q <= 1'b0;
                            if (!r_bus_we) begin
                                r_rdata_q <= bus_rdata;
                            end
                        end
                    end else if (w_expired) begin
                        r_bus_req <= 1'b0;
                        if (!int_clr) begin
                            r_err_q   <= 1'b1;
                            r_rdata_q <= 32'h0000_0000;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus_ack || w_expired) begin
                        r_bus_req <= 1'b0;
                    end
                end
                default: begin
                    r_bus_req <= r_bus_req;
                end
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign rdata_out = r_rdata_q;
    assign bus_err   = r_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; the timeout scenario runs only
// when MEM_BUS_TIMEOUT_EN is defined, otherwise an unbounded-wait scenario runs.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_clr;
    logic        LOAD_MEM;
    logic        STORE_MEM;
    logic        EXC_MEM_nz;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  be_in;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        MEM_MMID_en;
    logic        MEM_MMID_clr;
    logic        stall_mem;
    logic [31:0] rdata_out;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    logic [2:0] ctl;
    assign ctl = {bus_req, stall_mem, MEM_MMID_clr};

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .int_clr(int_clr),
        .LOAD_MEM(LOAD_MEM), .STORE_MEM(STORE_MEM), .EXC_MEM_nz(EXC_MEM_nz),
        .addr_in(addr_in), .wdata_in(wdata_in), .be_in(be_in),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .MEM_MMID_en(MEM_MMID_en), .MEM_MMID_clr(MEM_MMID_clr),
        .stall_mem(stall_mem), .rdata_out(rdata_out), .bus_err(bus_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        LOAD_MEM = 1'b0; STORE_MEM = 1'b0; EXC_MEM_nz = 1'b0;
        int_clr = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_in();
        addr_in = 32'h0; wdata_in = 32'h0; be_in = 4'h0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        total++; if ({ctl, MEM_MMID_en} !== 4'b0001) begin bad++; $display("FAIL reset_ctl: got %b exp 0001", {ctl, MEM_MMID_en}); end
        total++; if ({rdata_out, bus_err, bus_we, bus_addr} !== 66'h0) begin bad++; $display("FAIL reset_regs: rdata=%h err=%b we=%b addr=%h", rdata_out, bus_err, bus_we, bus_addr); end
    endtask

    task automatic test_load();
        cyc();
        LOAD_MEM = 1'b1; addr_in = 32'h100; be_in = 4'hF; wdata_in = 32'h0;
        #1;
        total++; if (ctl !== 3'b011) begin bad++; $display("FAIL load_issue: got %b exp 011", ctl); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        total++; if ({ctl, bus_we, bus_addr} !== {3'b111, 1'b0, 32'h100}) begin bad++; $display("FAIL load_wait: ctl=%b we=%b addr=%h", ctl, bus_we, bus_addr); end
        cyc();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        total++; if ({ctl, MEM_MMID_en, bus_err} !== 5'b00010) begin bad++; $display("FAIL load_done_ctl: got %b exp 00010", {ctl, MEM_MMID_en, bus_err}); end
        total++; if (rdata_out !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data: got %h exp deadbeef", rdata_out); end
        cyc();
        idle_in();
        #1;
        total++; if ({ctl, MEM_MMID_en} !== 4'b0001) begin bad++; $display("FAIL load_idle: got %b exp 0001", {ctl, MEM_MMID_en}); end
    endtask

    task automatic test_store_delay();
        STORE_MEM = 1'b1; addr_in = 32'h2040; wdata_in = 32'hCAFE1234; be_in = 4'b0011;
        #1;
        total++; if (ctl !== 3'b011) begin bad++; $display("FAIL store_issue: got %b exp 011", ctl); end
        for (int i = 1; i <= 5; i++) begin
            cyc();
            addr_in = 32'hFFFF_0000 + i; wdata_in = 32'h0; be_in = 4'hC;
            bus_ack = (i == 5);
            #1;
            total++;
            if ({ctl, bus_we, bus_be, bus_addr, bus_wdata} !== {3'b111, 1'b1, 4'b0011, 32'h2040, 32'hCAFE1234}) begin
                bad++; $display("FAIL store_wait%0d: ctl=%b we=%b be=%b addr=%h wd=%h", i, ctl, bus_we, bus_be, bus_addr, bus_wdata);
            end
        end
        cyc();
        bus_ack = 1'b0;
        #1;
        total++; if ({ctl, MEM_MMID_en, rdata_out} !== {4'b0001, 32'hDEADBEEF}) begin bad++; $display("FAIL store_done: ctl=%b en=%b rdata=%h", ctl, MEM_MMID_en, rdata_out); end
        cyc();
        idle_in();
    endtask

    task automatic test_back_to_back();
        LOAD_MEM = 1'b1; addr_in = 32'h300; be_in = 4'hF;
        #1;
        total++; if (ctl !== 3'b011) begin bad++; $display("FAIL b2b_issue1: got %b exp 011", ctl); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        cyc();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        total++; if ({ctl, rdata_out} !== {3'b000, 32'h11223344}) begin bad++; $display("FAIL b2b_done1: ctl=%b rdata=%h", ctl, rdata_out); end
        cyc();
        LOAD_MEM = 1'b0; STORE_MEM = 1'b1; addr_in = 32'h304; wdata_in = 32'hA5A5A5A5;
        #1;
        total++; if (ctl !== 3'b011) begin bad++; $display("FAIL b2b_issue2: got %b exp 011", ctl); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h77777777;
        #1;
        total++; if ({ctl, bus_we, bus_addr, bus_wdata} !== {3'b111, 1'b1, 32'h304, 32'hA5A5A5A5}) begin bad++; $display("FAIL b2b_wait2: ctl=%b we=%b addr=%h wd=%h", ctl, bus_we, bus_addr, bus_wdata); end
        cyc();
        bus_ack = 1'b0;
        #1;
        total++; if ({ctl, MEM_MMID_en, rdata_out} !== {4'b0001, 32'h11223344}) begin bad++; $display("FAIL b2b_done2: ctl=%b en=%b rdata=%h", ctl, MEM_MMID_en, rdata_out); end
        cyc();
        idle_in();
    endtask

    task automatic test_int_clr();
        LOAD_MEM = 1'b1; addr_in = 32'h400;
        cyc();
        #1;
        total++; if (ctl !== 3'b111) begin bad++; $display("FAIL flush_wait1: got %b exp 111", ctl); end
        cyc();
        int_clr = 1'b1; LOAD_MEM = 1'b0;
        #1;
        total++; if (ctl !== 3'b111) begin bad++; $display("FAIL flush_wait2: got %b exp 111", ctl); end
        cyc();
        int_clr = 1'b0;
        #1;
        total++; if (ctl !== 3'b111) begin bad++; $display("FAIL flush_drain3: got %b exp 111", ctl); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        #1;
        total++; if (ctl !== 3'b111) begin bad++; $display("FAIL flush_drain4: got %b exp 111", ctl); end
        cyc();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        total++; if ({ctl, MEM_MMID_en, rdata_out} !== {4'b0001, 32'h11223344}) begin bad++; $display("FAIL flush_idle: ctl=%b en=%b rdata=%h", ctl, MEM_MMID_en, rdata_out); end
    endtask

    task automatic test_exc_nop();
        LOAD_MEM = 1'b1; EXC_MEM_nz = 1'b1;
        #1;
        total++; if ({ctl, MEM_MMID_en} !== 4'b0001) begin bad++; $display("FAIL exc_load: got %b exp 0001", {ctl, MEM_MMID_en}); end
        cyc();
        EXC_MEM_nz = 1'b0; LOAD_MEM = 1'b0;
        #1;
        total++; if ({ctl, MEM_MMID_en} !== 4'b0001) begin bad++; $display("FAIL alu_op: got %b exp 0001", {ctl, MEM_MMID_en}); end
        STORE_MEM = 1'b1; int_clr = 1'b1;
        cyc();
        idle_in();
        #1;
        total++; if ({ctl, MEM_MMID_en} !== 4'b0001) begin bad++; $display("FAIL flushed_store: got %b exp 0001", {ctl, MEM_MMID_en}); end
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        LOAD_MEM = 1'b1; addr_in = 32'h500;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            #1;
            total++; if (ctl !== 3'b111) begin bad++; $display("FAIL to_wait%0d: got %b exp 111", i, ctl); end
        end
        cyc();
        #1;
        total++; if ({ctl, bus_err, rdata_out} !== {3'b000, 1'b1, 32'h0}) begin bad++; $display("FAIL to_done: ctl=%b err=%b rdata=%h", ctl, bus_err, rdata_out); end
        cyc();
        addr_in = 32'h504;
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        cyc();
        bus_ack = 1'b0;
        #1;
        total++; if ({bus_err, rdata_out} !== {1'b0, 32'h0BADF00D}) begin bad++; $display("FAIL to_recover: err=%b rdata=%h", bus_err, rdata_out); end
        cyc();
        idle_in();
    endtask
`else
    task automatic test_long_wait();
        LOAD_MEM = 1'b1; addr_in = 32'h500;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            #1;
            total++; if ({ctl, bus_err} !== 4'b1110) begin bad++; $display("FAIL long_wait%0d: got %b exp 1110", i, {ctl, bus_err}); end
        end
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        cyc();
        bus_ack = 1'b0;
        #1;
        total++; if ({ctl, bus_err, rdata_out} !== {3'b000, 1'b0, 32'h0BADF00D}) begin bad++; $display("FAIL long_done: ctl=%b err=%b rdata=%h", ctl, bus_err, rdata_out); end
        cyc();
        idle_in();
    endtask
`endif

    task automatic test_reset_mid_wait();
        LOAD_MEM = 1'b1; addr_in = 32'h600;
        cyc();
        #1;
        total++; if (ctl !== 3'b111) begin bad++; $display("FAIL rstw_wait: got %b exp 111", ctl); end
        reset = 1'b1;
        cyc();
        reset = 1'b0; LOAD_MEM = 1'b0;
        #1;
        total++; if ({ctl, MEM_MMID_en, bus_err, bus_we} !== 6'b000100) begin bad++; $display("FAIL rstw_ctl: got %b exp 000100", {ctl, MEM_MMID_en, bus_err, bus_we}); end
        total++; if ({rdata_out, bus_addr} !== 64'h0) begin bad++; $display("FAIL rstw_regs: rdata=%h addr=%h", rdata_out, bus_addr); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_delay();
        test_back_to_back();
        test_int_clr();
        test_exc_nop();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
